// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    NO_FWD  = 2'b00,
    WB_FWD  = 2'b01,
    MEM_FWD = 2'b10
  } fwd_sel_t;

  localparam int MDU_LAT_DEF = 8;

endpackage

// File: rtl/mdu_scoreboard.sv
// Pending-write scoreboard and latency countdown for the single non-pipelined MDU.
module mdu_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREGS   = 32,
  parameter int MDU_LAT = MDU_LAT_DEF,
  parameter int AW      = $clog2(NREGS),
  parameter int CW      = $clog2(MDU_LAT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [AW-1:0]      startRd,
  input  logic [2:0][AW-1:0] lookupAddr,
  output logic [2:0]         lookupHit,
  output logic               busy,
  output logic               wbEn,
  output logic [AW-1:0]      wbRd
);

  localparam logic [CW-1:0] LAT_C = CW'(MDU_LAT);

  logic [NREGS-1:0] sb;
  logic [CW-1:0]    cnt;

  assign busy = (cnt != '0);
  assign wbEn = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= LAT_C;
    end else if (busy) begin
      cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbRd <= '0;
    end else if (start) begin
      wbRd <= startRd;
    end
  end

  // start and wbEn never coincide (a busy unit blocks issue), but set wins anyway
  always_ff @(posedge clk) begin
    if (rst) begin
      sb <= '0;
    end else begin
      if (wbEn) sb[wbRd] <= 1'b0;
      if (start && startRd != '0) sb[startRd] <= 1'b1;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_lookup
    assign lookupHit[i] = sb[lookupAddr[i]];
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard controller: forwarding selects, stalls/flushes, and MDU issue/writeback control.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREGS   = 32,
  parameter int AW      = $clog2(NREGS),
  parameter int MDU_LAT = MDU_LAT_DEF,
  parameter int CW      = $clog2(MDU_LAT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] r1AddrD,
  input  logic [AW-1:0] r2AddrD,
  input  logic [AW-1:0] rdD,
  input  logic          regWriteD,
  input  logic          mduOpD,
  input  logic [AW-1:0] r1AddrE,
  input  logic [AW-1:0] r2AddrE,
  input  logic [AW-1:0] rdE,
  input  logic          regSrcE0,
  input  logic [AW-1:0] rdM,
  input  logic [AW-1:0] rdW,
  input  logic          regWriteM,
  input  logic          regWriteW,
  input  logic          usePredict,
  input  logic          pcSelE,
  input  logic          wrongBranchE,
  output logic [1:0]    fwdAE,
  output logic [1:0]    fwdBE,
  output logic          stallF,
  output logic          stallD,
  output logic          flushD,
  output logic          flushE,
  output logic          mduStart,
  output logic          mduWbEn,
  output logic [AW-1:0] mduWbRd,
  output logic          mduBusy
);

  function automatic fwd_sel_t fwdSel(input logic [AW-1:0] addrE,
                                      input logic [AW-1:0] rM, input logic wM,
                                      input logic [AW-1:0] rW, input logic wW);
    if (wM && rM != '0 && addrE == rM) return MEM_FWD;
    if (wW && rW != '0 && addrE == rW) return WB_FWD;
    return NO_FWD;
  endfunction

  assign fwdAE = fwdSel(r1AddrE, rdM, regWriteM, rdW, regWriteW);
  assign fwdBE = fwdSel(r2AddrE, rdM, regWriteM, rdW, regWriteW);

  logic [2:0] sbHit;
  logic       bKill, loadUse, sbRaw, sbWaw, mduStruct, hold;

  assign bKill = usePredict ? wrongBranchE : pcSelE;

  assign loadUse   = regSrcE0 && rdE != '0 && (r1AddrD == rdE || r2AddrD == rdE);
  assign sbRaw     = (sbHit[0] && r1AddrD != '0) || (sbHit[1] && r2AddrD != '0);
  assign sbWaw     = regWriteD && sbHit[2] && rdD != '0;
  assign mduStruct = mduOpD && mduBusy;
  assign hold      = loadUse || sbRaw || sbWaw || mduStruct;

  // a kill discards the D instruction, so it overrides any stall
  assign stallF   = hold && !bKill;
  assign stallD   = hold && !bKill;
  assign flushD   = bKill;
  assign flushE   = bKill || hold;
  assign mduStart = mduOpD && regWriteD && !hold && !bKill;

  mdu_scoreboard #(
    .NREGS  (NREGS),
    .MDU_LAT(MDU_LAT),
    .AW     (AW),
    .CW     (CW)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .start     (mduStart),
    .startRd   (rdD),
    .lookupAddr({rdD, r2AddrD, r1AddrD}),
    .lookupHit (sbHit),
    .busy      (mduBusy),
    .wbEn      (mduWbEn),
    .wbRd      (mduWbRd)
  );

endmodule
